mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port `MEMORY` between the `cpu` core and a DMA/debug requester. It sits between both masters and the memory and drives the memory address, write-enable and write data. Fairness is programmable: the CPU has default priority, and a starvation timer with a burst limit guarantees DMA progress. It also exposes a saturating CPU-stall counter for performance monitoring.

---
 rtl/mem_arbiter.sv | 86 ++++++++
 tb/tb_mem_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares a single-port memory between the CPU and a DMA/debug requester.
// The CPU has default priority; a starvation timer and a burst limit guarantee DMA progress.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_BURST    = 4
) (
  input  logic        CLK,
  input  logic        R,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_rdy,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_rdy,
  output logic [7:0]  rdata,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        dma_owner,
  output logic [15:0] stall_cnt
);

  typedef enum logic {PRI_CPU, PRI_DMA} pri_t;

  localparam logic [3:0] WAIT_LAST  = 4'(STARVE_LIMIT - 1);
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  pri_t       pri;
  logic [3:0] wait_cnt;
  logic [3:0] burst_cnt;
  logic       grant_dma;

  // Grant is qualified by R so a write is suppressed as soon as reset asserts.
  always_comb begin
    grant_dma = R && dma_req && (!cpu_req || (pri == PRI_DMA));
    dma_owner = grant_dma;
    dma_rdy   = grant_dma;
    cpu_rdy   = R && !(cpu_req && grant_dma);
    mem_addr  = grant_dma ? dma_addr  : cpu_addr;
    mem_wdata = grant_dma ? dma_wdata : cpu_wdata;
    mem_we    = R && (grant_dma ? (dma_we && dma_req) : (cpu_we && cpu_req));
    rdata     = mem_rdata;
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      pri       <= PRI_CPU;
      wait_cnt  <= '0;
      burst_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (cpu_req && !cpu_rdy && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 16'd1;

      case (pri)
        PRI_CPU: begin
          if (dma_req && !grant_dma) begin
            if (wait_cnt == WAIT_LAST) begin
              pri      <= PRI_DMA;
              wait_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + 4'd1;
            end
          end else begin
            wait_cnt <= '0;
          end
        end
        PRI_DMA: begin
          if (!dma_req || (burst_cnt == BURST_LAST)) begin
            pri       <= PRI_CPU;
            burst_cnt <= '0;
          end else begin
            burst_cnt <= burst_cnt + 4'd1;
          end
        end
        default: pri <= PRI_CPU;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vectors, a per-cycle behavioural model,
// and a second instance driven into stall-counter saturation.
module tb_mem_arbiter;

  localparam int SL = 4;
  localparam int MB = 4;

  logic        CLK = 1'b0;
  logic        R;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata;
  logic        cpu_rdy, dma_rdy, dma_owner, mem_we;
  logic [7:0]  rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr, stall_cnt;

  logic        s_R, s_req;
  logic        s_cpu_rdy, s_dma_rdy, s_dma_owner, s_mem_we;
  logic [7:0]  s_rdata, s_mem_wdata;
  logic [15:0] s_mem_addr, s_stall_cnt;
  logic        sat_done = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] tb_mem [0:65535];

  always #5 CLK = ~CLK;

  mem_arbiter #(.STARVE_LIMIT(SL), .MAX_BURST(MB)) u_dut (
    .CLK(CLK), .R(R),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdy(cpu_rdy),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rdy(dma_rdy),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dma_owner(dma_owner), .stall_cnt(stall_cnt)
  );

  mem_arbiter #(.STARVE_LIMIT(1), .MAX_BURST(15)) u_sat (
    .CLK(CLK), .R(s_R),
    .cpu_req(s_req), .cpu_we(1'b0), .cpu_addr(16'h0000), .cpu_wdata(8'h00), .cpu_rdy(s_cpu_rdy),
    .dma_req(s_req), .dma_we(1'b0), .dma_addr(16'h0001), .dma_wdata(8'h00), .dma_rdy(s_dma_rdy),
    .rdata(s_rdata), .mem_addr(s_mem_addr), .mem_we(s_mem_we), .mem_wdata(s_mem_wdata), .mem_rdata(8'h00),
    .dma_owner(s_dma_owner), .stall_cnt(s_stall_cnt)
  );

  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge CLK) if (mem_we) tb_mem[mem_addr] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: priority flag, denial streak, burst length and stall total as plain ints.
  bit m_dma_pri = 1'b0;
  int m_denied  = 0;
  int m_burst   = 0;
  int m_stall   = 0;

  function automatic bit exp_dma_grant();
    return R && dma_req && (!cpu_req || m_dma_pri);
  endfunction

  always @(posedge CLK or negedge R) begin
    if (!R) begin
      m_dma_pri <= 1'b0;
      m_denied  <= 0;
      m_burst   <= 0;
      m_stall   <= 0;
    end else begin
      if (cpu_req && exp_dma_grant())
        m_stall <= (m_stall >= 65535) ? 65535 : m_stall + 1;
      if (!m_dma_pri) begin
        if (dma_req && !exp_dma_grant()) begin
          if (m_denied + 1 >= SL) begin
            m_dma_pri <= 1'b1;
            m_denied  <= 0;
          end else begin
            m_denied <= m_denied + 1;
          end
        end else begin
          m_denied <= 0;
        end
      end else begin
        if (!dma_req || (m_burst + 1 >= MB)) begin
          m_dma_pri <= 1'b0;
          m_burst   <= 0;
        end else begin
          m_burst <= m_burst + 1;
        end
      end
    end
  end

  always @(negedge CLK) begin
    bit          g;
    logic [15:0] ea;
    g  = exp_dma_grant();
    ea = g ? dma_addr : cpu_addr;
    chk("m_dma_owner", dma_owner, g);
    chk("m_dma_rdy",   dma_rdy,   g);
    chk("m_cpu_rdy",   cpu_rdy,   R && !(cpu_req && g));
    chk("m_mem_we",    mem_we,    R && (g ? (dma_req && dma_we) : (cpu_req && cpu_we)));
    chk("m_mem_addr",  mem_addr,  ea);
    chk("m_mem_wdata", mem_wdata, g ? dma_wdata : cpu_wdata);
    chk("m_rdata",     rdata,     tb_mem[ea]);
    chk("m_stall_cnt", stall_cnt, m_stall[15:0]);
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Saturation instance: STARVE_LIMIT=1, MAX_BURST=15 gives 15 stalls per 16 cycles.
  initial begin
    s_R   = 1'b0;
    s_req = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    s_R = 1'b1;
    repeat (160) @(posedge CLK);
    #1 chk("sat_progress", s_stall_cnt, 32'd150);
    repeat (69904 - 160) @(posedge CLK);
    #1 chk("sat_reach", s_stall_cnt, 32'h0000FFFF);
    repeat (64) @(posedge CLK);
    #1 chk("sat_hold", s_stall_cnt, 32'h0000FFFF);
    sat_done = 1'b1;
  end

  initial begin
    bit starve_pat [16];
    bit early_pat  [12];
    for (int unsigned a = 0; a < 65536; a++) tb_mem[a] = 8'h00;
    starve_pat = '{1,1,1,1, 0,0,0,0, 1,1,1,1, 0,0,0,0};
    early_pat  = '{0,0,0,0, 1,1,0, 0,0,0,0, 1};

    R = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'hA5;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0300; dma_wdata = 8'h3C;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_mem_we",    mem_we,    32'd0);
    chk("rst_cpu_rdy",   cpu_rdy,   32'd0);
    chk("rst_dma_rdy",   dma_rdy,   32'd0);
    chk("rst_dma_owner", dma_owner, 32'd0);
    chk("rst_stall",     stall_cnt, 32'd0);
    chk("rst_mem_addr",  mem_addr,  32'h1234);

    next_cycle();
    R = 1'b1;
    #2;
    chk("rel_cpu_rdy",   cpu_rdy,   32'd1);
    chk("rel_dma_owner", dma_owner, 32'd0);
    chk("rel_mem_addr",  mem_addr,  32'h1234);

    next_cycle();
    cpu_req = 1'b0; cpu_we = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
    repeat (2) next_cycle();

    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0200; dma_wdata = 8'h5A;
    @(negedge CLK);
    chk("single_dma_rdy",  dma_rdy,  32'd1);
    chk("single_mem_addr", mem_addr, 32'h0200);
    chk("single_mem_we",   mem_we,   32'd1);
    next_cycle();
    dma_req = 1'b0; dma_we = 1'b0;
    cpu_req = 1'b1; cpu_addr = 16'h0200;
    @(negedge CLK);
    chk("readback_rdata",   rdata,   32'h5A);
    chk("readback_cpu_rdy", cpu_rdy, 32'd1);
    next_cycle();
    cpu_req = 1'b0;
    next_cycle();

    cpu_req = 1'b1; dma_req = 1'b1; cpu_addr = 16'h1234;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      chk($sformatf("starve_cpu_rdy[%0d]", i), cpu_rdy, starve_pat[i]);
      chk($sformatf("starve_owner[%0d]", i), dma_owner, !starve_pat[i]);
      if (i == 12) chk("starve_stall12", stall_cnt, 32'd4);
      next_cycle();
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    next_cycle();

    cpu_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      dma_req = (i != 6);
      @(negedge CLK);
      chk($sformatf("early_dma_rdy[%0d]", i), dma_rdy, early_pat[i]);
      next_cycle();
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    repeat (2) next_cycle();

    cpu_req = 1'b1; dma_req = 1'b1; dma_we = 1'b1; dma_wdata = 8'h77; dma_addr = 16'h0400;
    repeat (5) next_cycle();
    chk("burst_we", mem_we, 32'd1);
    R = 1'b0;
    #1;
    chk("midrst_mem_we",  mem_we,  32'd0);
    chk("midrst_dma_rdy", dma_rdy, 32'd0);
    next_cycle();
    R = 1'b1;
    #1;
    chk("midrst_cpu_first", cpu_rdy,   32'd1);
    chk("midrst_owner",     dma_owner, 32'd0);
    next_cycle();
    cpu_req = 1'b0; dma_req = 1'b0; dma_we = 1'b0;

    for (int k = 0; k < 80000 && !sat_done; k++) @(posedge CLK);
    if (!sat_done) chk("sat_timeout", 32'd0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
